// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters.
// Each operation takes IDLE(handshake) -> EXEC -> RESP; status flags update on S.
module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int FLAG_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_in1,
   input  logic [DATA_W-1:0] req0_in2,
   input  logic [3:0]        req0_opcode,
   input  logic [3:0]        req0_cond,
   input  logic [4:0]        req0_sr_bit,
   input  logic [2:0]        req0_sr_cont,
   input  logic              req0_s,
   input  logic [15:0]       req0_imm,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_in1,
   input  logic [DATA_W-1:0] req1_in2,
   input  logic [3:0]        req1_opcode,
   input  logic [3:0]        req1_cond,
   input  logic [4:0]        req1_sr_bit,
   input  logic [2:0]        req1_sr_cont,
   input  logic              req1_s,
   input  logic [15:0]       req1_imm,
   output logic              resp0_valid,
   output logic [DATA_W-1:0] resp0_out,
   output logic [FLAG_W-1:0] resp0_flags,
   output logic              resp1_valid,
   output logic [DATA_W-1:0] resp1_out,
   output logic [FLAG_W-1:0] resp1_flags,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [3:0]        alu_opcode,
   output logic [3:0]        alu_cond,
   output logic [4:0]        alu_sr_bit,
   output logic [2:0]        alu_sr_cont,
   output logic              alu_s,
   output logic [15:0]       alu_imm,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [FLAG_W-1:0] alu_flags,
   output logic [FLAG_W-1:0] flags_q,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state_q, state_d;
   logic              last_grant_q, grant_q;
   logic              gnt0, gnt1;
   logic [DATA_W-1:0] in1_q, in2_q;
   logic [3:0]        opcode_q, cond_q;
   logic [4:0]        sr_bit_q;
   logic [2:0]        sr_cont_q;
   logic              s_q;
   logic [15:0]       imm_q;
   logic              resp0_valid_q, resp1_valid_q;
   logic [DATA_W-1:0] resp0_out_q, resp1_out_q;
   logic [FLAG_W-1:0] resp0_flags_q, resp1_flags_q;

   // On contention the requester that did not win last time is served.
   assign gnt0 = req0_valid & (~req1_valid | last_grant_q);
   assign gnt1 = req1_valid & (~req0_valid | ~last_grant_q);

   assign req0_ready = (state_q == IDLE) & gnt0;
   assign req1_ready = (state_q == IDLE) & gnt1;
   assign busy       = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (gnt0 | gnt1) state_d = EXEC;
         EXEC:    state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         last_grant_q  <= 1'b1;
         grant_q       <= 1'b0;
         in1_q         <= '0;
         in2_q         <= '0;
         opcode_q      <= '0;
         cond_q        <= '0;
         sr_bit_q      <= '0;
         sr_cont_q     <= '0;
         s_q           <= 1'b0;
         imm_q         <= '0;
         resp0_valid_q <= 1'b0;
         resp1_valid_q <= 1'b0;
         resp0_out_q   <= '0;
         resp1_out_q   <= '0;
         resp0_flags_q <= '0;
         resp1_flags_q <= '0;
         flags_q       <= '0;
      end else begin
         state_q       <= state_d;
         resp0_valid_q <= 1'b0;
         resp1_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (gnt0 | gnt1) begin
                  grant_q      <= gnt1;
                  last_grant_q <= gnt1;
                  in1_q        <= gnt1 ? req1_in1     : req0_in1;
                  in2_q        <= gnt1 ? req1_in2     : req0_in2;
                  opcode_q     <= gnt1 ? req1_opcode  : req0_opcode;
                  cond_q       <= gnt1 ? req1_cond    : req0_cond;
                  sr_bit_q     <= gnt1 ? req1_sr_bit  : req0_sr_bit;
                  sr_cont_q    <= gnt1 ? req1_sr_cont : req0_sr_cont;
                  s_q          <= gnt1 ? req1_s       : req0_s;
                  imm_q        <= gnt1 ? req1_imm     : req0_imm;
               end
            end
            EXEC: begin
               // Result capture and flag update share the edge that raises the strobe.
               if (grant_q) begin
                  resp1_valid_q <= 1'b1;
                  resp1_out_q   <= alu_out;
                  resp1_flags_q <= alu_flags;
               end else begin
                  resp0_valid_q <= 1'b1;
                  resp0_out_q   <= alu_out;
                  resp0_flags_q <= alu_flags;
               end
               if (s_q) flags_q <= alu_flags;
            end
            default: ;
         endcase
      end
   end

   assign alu_in1     = in1_q;
   assign alu_in2     = in2_q;
   assign alu_opcode  = opcode_q;
   assign alu_cond    = cond_q;
   assign alu_sr_bit  = sr_bit_q;
   assign alu_sr_cont = sr_cont_q;
   assign alu_s       = s_q;
   assign alu_imm     = imm_q;

   assign resp0_valid = resp0_valid_q;
   assign resp1_valid = resp1_valid_q;
   assign resp0_out   = resp0_out_q;
   assign resp1_out   = resp1_out_q;
   assign resp0_flags = resp0_flags_q;
   assign resp1_flags = resp1_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU on the alu_* ports, vector table plus
// directed tie/reset/late-request sequences, scoreboard checks every response.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 0, req1_valid = 0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_in1 = 0, req0_in2 = 0, req1_in1 = 0, req1_in2 = 0;
   logic [3:0]  req0_opcode = 0, req0_cond = 0, req1_opcode = 0, req1_cond = 0;
   logic [4:0]  req0_sr_bit = 0, req1_sr_bit = 0;
   logic [2:0]  req0_sr_cont = 0, req1_sr_cont = 0;
   logic        req0_s = 0, req1_s = 0;
   logic [15:0] req0_imm = 0, req1_imm = 0;
   logic        resp0_valid, resp1_valid;
   logic [31:0] resp0_out, resp1_out;
   logic [3:0]  resp0_flags, resp1_flags;
   logic [31:0] alu_in1, alu_in2, alu_out;
   logic [3:0]  alu_opcode, alu_cond, alu_flags;
   logic [4:0]  alu_sr_bit;
   logic [2:0]  alu_sr_cont;
   logic        alu_s;
   logic [15:0] alu_imm;
   logic [3:0]  flags_q;
   logic        busy;

   alu_arbiter #(.DATA_W(32), .FLAG_W(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1), .req0_in2(req0_in2),
      .req0_opcode(req0_opcode), .req0_cond(req0_cond), .req0_sr_bit(req0_sr_bit),
      .req0_sr_cont(req0_sr_cont), .req0_s(req0_s), .req0_imm(req0_imm),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1), .req1_in2(req1_in2),
      .req1_opcode(req1_opcode), .req1_cond(req1_cond), .req1_sr_bit(req1_sr_bit),
      .req1_sr_cont(req1_sr_cont), .req1_s(req1_s), .req1_imm(req1_imm),
      .resp0_valid(resp0_valid), .resp0_out(resp0_out), .resp0_flags(resp0_flags),
      .resp1_valid(resp1_valid), .resp1_out(resp1_out), .resp1_flags(resp1_flags),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode), .alu_cond(alu_cond),
      .alu_sr_bit(alu_sr_bit), .alu_sr_cont(alu_sr_cont), .alu_s(alu_s), .alu_imm(alu_imm),
      .alu_out(alu_out), .alu_flags(alu_flags), .flags_q(flags_q), .busy(busy)
   );

   always #5 clk = ~clk;

   // Flags are {N, Z, C, V}; every ALU input field influences some opcode.
   function automatic logic [35:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [3:0] cond,
                                             input logic [4:0] srb, input logic [2:0] src,
                                             input logic s, input logic [15:0] imm);
      logic [32:0] w;
      logic [31:0] o;
      logic        c, v;
      c = 1'b0; v = 1'b0; w = '0;
      case (op)
         4'd0: begin w = {1'b0, a} + {1'b0, b}; o = w[31:0]; c = w[32];
                     v = (a[31] == b[31]) && (o[31] != a[31]); end
         4'd1: begin w = {1'b0, a} + {1'b0, ~b} + 33'd1; o = w[31:0]; c = w[32];
                     v = (a[31] != b[31]) && (o[31] != a[31]); end
         4'd2: o = a & b;
         4'd3: o = a | b;
         4'd4: o = a ^ b;
         4'd5: o = b;
         4'd6: o = a << srb;
         4'd7: o = a ^ {16'h0, imm};
         4'd8: o = a + {24'h0, cond, src, s};
         default: o = a;
      endcase
      return {o[31], (o == 32'd0), c, v, o};
   endfunction

   always_comb {alu_flags, alu_out} = alu_model(alu_opcode, alu_in1, alu_in2, alu_cond,
                                                alu_sr_bit, alu_sr_cont, alu_s, alu_imm);

   typedef struct {
      bit          id;
      logic [31:0] in1, in2;
      logic [3:0]  op, cond;
      logic [4:0]  srb;
      logic [2:0]  src;
      bit          s;
      logic [15:0] imm;
      logic [31:0] exp_out;
      logic [3:0]  exp_flags;
   } vec_t;

   typedef struct {
      bit          id;
      logic [31:0] out;
      logic [3:0]  flags;
      bit          s;
      int          hs;
   } exp_t;

   exp_t        sb[$];
   int          nvec = 0, errs = 0, cyc = 0;
   logic [3:0]  mflags = 4'h0;
   vec_t        tbl[10];

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(input bit id, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] op, input bit s);
      vec_t        v;
      logic [35:0] r;
      r = alu_model(op, a, b, 4'h0, 5'h0, 3'h0, s, 16'h0);
      v = '{id, a, b, op, 4'h0, 5'h0, 3'h0, s, 16'h0, r[31:0], r[35:32]};
      return v;
   endfunction

   task automatic drive(input vec_t v, input logic valid);
      if (v.id) begin
         req1_in1 = v.in1; req1_in2 = v.in2; req1_opcode = v.op; req1_cond = v.cond;
         req1_sr_bit = v.srb; req1_sr_cont = v.src; req1_s = v.s; req1_imm = v.imm;
         req1_valid = valid;
      end else begin
         req0_in1 = v.in1; req0_in2 = v.in2; req0_opcode = v.op; req0_cond = v.cond;
         req0_sr_bit = v.srb; req0_sr_cont = v.src; req0_s = v.s; req0_imm = v.imm;
         req0_valid = valid;
      end
   endtask

   task automatic push(input vec_t v);
      exp_t e;
      e.id = v.id; e.out = v.exp_out; e.flags = v.exp_flags; e.s = v.s; e.hs = cyc;
      sb.push_back(e);
   endtask

   // Drive one request and wait (bounded) for its handshake; returns one
   // tick after the handshake edge, i.e. early in the EXEC cycle.
   task automatic issue(input vec_t v);
      bit done;
      done = 0;
      @(posedge clk) #1;
      drive(v, 1'b1);
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (v.id ? req1_ready : req0_ready) begin
            push(v);
            done = 1;
         end
      end
      if (!done) check("handshake_timeout", 32'(done), 32'd1);
      @(posedge clk) #1;
      drive(v, 1'b0);
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
      check("pending_responses", 32'(sb.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         mflags = 4'h0;
         sb.delete();
      end else if (resp0_valid || resp1_valid) begin
         check("resp_both_valid", 32'(resp0_valid & resp1_valid), 32'd0);
         if (sb.size() == 0) begin
            check("resp_spurious", {30'd0, resp1_valid, resp0_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("resp_id", 32'(resp1_valid), 32'(e.id));
            check("resp_out", e.id ? resp1_out : resp0_out, e.out);
            check("resp_flags", 32'(e.id ? resp1_flags : resp0_flags), 32'(e.flags));
            check("resp_latency", 32'(cyc - e.hs), 32'd2);
            if (e.s) mflags = e.flags;
            check("flags_q", 32'(flags_q), 32'(mflags));
         end
      end
   end

   initial begin
      vec_t v0, v1;
      int   n, bcnt;
      int   order[4], t[4];

      tbl[0] = '{1'b0, 32'd5,          32'd3,          4'd0, 4'h0, 5'd0,  3'd0,   1'b1, 16'h0,    32'd8,          4'b0000};
      tbl[1] = '{1'b1, 32'h7FFFFFFF,   32'h7FFFFFFF,   4'd0, 4'h0, 5'd0,  3'd0,   1'b1, 16'h0,    32'hFFFFFFFE,   4'b1001};
      tbl[2] = '{1'b0, 32'd3,          32'd5,          4'd1, 4'h0, 5'd0,  3'd0,   1'b1, 16'h0,    32'hFFFFFFFE,   4'b1000};
      tbl[3] = '{1'b1, 32'd5,          32'd5,          4'd1, 4'h0, 5'd0,  3'd0,   1'b1, 16'h0,    32'd0,          4'b0110};
      tbl[4] = '{1'b0, 32'hF0F0F0F0,   32'h0FF00FF0,   4'd2, 4'h0, 5'd0,  3'd0,   1'b0, 16'h0,    32'h00F000F0,   4'b0000};
      tbl[5] = '{1'b1, 32'd1,          32'd0,          4'd6, 4'h0, 5'd31, 3'd0,   1'b1, 16'h0,    32'h80000000,   4'b1000};
      tbl[6] = '{1'b0, 32'hFFFF0000,   32'd0,          4'd7, 4'h0, 5'd0,  3'd0,   1'b0, 16'hABCD, 32'hFFFFABCD,   4'b1000};
      tbl[7] = '{1'b1, 32'h10,         32'd0,          4'd8, 4'hA, 5'd0,  3'b101, 1'b1, 16'h0,    32'hBB,         4'b0000};
      tbl[8] = '{1'b0, 32'hFFFFFFFF,   32'd1,          4'd0, 4'h0, 5'd0,  3'd0,   1'b1, 16'h0,    32'd0,          4'b0110};
      tbl[9] = '{1'b1, 32'd0,          32'd0,          4'd3, 4'h0, 5'd0,  3'd0,   1'b1, 16'h0,    32'd0,          4'b0100};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready0", 32'(req0_ready), 32'd0);
      check("rst_ready1", 32'(req1_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_flags_q", 32'(flags_q), 32'd0);
      check("rst_resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd0);
      check("rst_alu_in1", alu_in1, 32'd0);
      check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
      check("rst_resp0_out", resp0_out, 32'd0);
      @(posedge clk) #1;
      rst = 1'b0;

      // Tie straight after reset: grants must alternate starting with req0
      v0 = mk(1'b0, 32'd1, 32'd2, 4'd0, 1'b1);
      v1 = mk(1'b1, 32'd9, 32'd4, 4'd1, 1'b0);
      drive(v0, 1'b1);
      drive(v1, 1'b1);
      n = 0;
      for (int k = 0; k < 40 && n < 4; k++) begin
         @(negedge clk);
         check("tie_ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
         if (req0_ready) begin push(v0); order[n] = 0; t[n] = cyc; n++; end
         else if (req1_ready) begin push(v1); order[n] = 1; t[n] = cyc; n++; end
      end
      @(posedge clk) #1;
      drive(v0, 1'b0);
      drive(v1, 1'b0);
      check("tie_grants", 32'(n), 32'd4);
      for (int i = 0; i < n; i++) check("tie_order", 32'(order[i]), 32'(i % 2));
      for (int i = 1; i < n; i++) check("tie_spacing", 32'(t[i] - t[i-1]), 32'd3);
      drain();

      // Vector table; busy must be high for exactly EXEC and RESP
      for (int i = 0; i < 10; i++) begin
         issue(tbl[i]);
         bcnt = 0;
         repeat (4) begin
            @(negedge clk);
            if (busy) bcnt++;
         end
         check("busy_cycles", 32'(bcnt), 32'd2);
         drain();
      end

      // Reset during EXEC abandons the op; next request accepted immediately
      issue(mk(1'b0, 32'd10, 32'd20, 4'd0, 1'b1));
      rst = 1'b1;
      @(negedge clk);
      @(posedge clk) #1;
      rst = 1'b0;
      v0 = mk(1'b0, 32'd7, 32'd7, 4'd0, 1'b1);
      drive(v0, 1'b1);
      @(negedge clk);
      check("rstmid_resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd0);
      check("rstmid_flags_q", 32'(flags_q), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_ready0", 32'(req0_ready), 32'd1);
      if (req0_ready) push(v0);
      @(posedge clk) #1;
      drive(v0, 1'b0);
      drain();

      // Late request raised during EXEC waits for the following IDLE
      v0 = mk(1'b0, 32'd100, 32'd1, 4'd1, 1'b1);
      v1 = mk(1'b1, 32'h8000_0000, 32'h8000_0000, 4'd0, 1'b1);
      @(posedge clk) #1;
      drive(v0, 1'b1);
      @(negedge clk);
      check("late_ready0", 32'(req0_ready), 32'd1);
      if (req0_ready) push(v0);
      @(posedge clk) #1;
      drive(v0, 1'b0);
      drive(v1, 1'b1);
      @(negedge clk);
      check("late_ready1_exec", 32'(req1_ready), 32'd0);
      @(posedge clk) #1;
      @(negedge clk);
      check("late_ready1_resp", 32'(req1_ready), 32'd0);
      @(posedge clk) #1;
      @(negedge clk);
      check("late_ready1_idle", 32'(req1_ready), 32'd1);
      if (req1_ready) push(v1);
      @(posedge clk) #1;
      drive(v1, 1'b0);
      drain();

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational `alu` instance between two requesters, e.g. the integer pipe (0) and the address/branch unit (1).
- Grants round-robin, registers the selected operands into the ALU, and captures Out/Flags into a result register.
- Returns the result to the winning requester and maintains the architectural status-flag register, which is written only when the S bit is set.

Parameters:
DATA_W, 32, operand/result width (must match alu)
FLAG_W, 4, width of alu Flags and status register

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
reqN_valid  input  1  requester N (N=0,1) has an operation pending
reqN_ready  output  1  arbiter accepts requester N's operation this cycle
reqN_in1  input  DATA_W  operand 1 from requester N
reqN_in2  input  DATA_W  operand 2 from requester N
reqN_opcode  input  4  ALU opcode from requester N
reqN_cond  input  4  condition field from requester N
reqN_sr_bit  input  5  shift amount from requester N
reqN_sr_cont  input  3  shift control from requester N
reqN_s  input  1  update status flags when 1
reqN_imm  input  16  immediate from requester N
respN_valid  output  1  one-cycle result strobe to requester N
respN_out  output  DATA_W  result to requester N
respN_flags  output  FLAG_W  flags produced by this operation
alu_in1, alu_in2  output  DATA_W  drive alu In1/In2
alu_opcode, alu_cond  output  4  drive alu Opcode/Cond
alu_sr_bit  output  5  drive alu SR_Bit
alu_sr_cont  output  3  drive alu SR_Cont
alu_s  output  1  drive alu S
alu_imm  output  16  drive alu Immediate
alu_out  input  DATA_W  alu Out
alu_flags  input  FLAG_W  alu Flags
flags_q  output  FLAG_W  architectural status flags
busy  output  1  high in EXEC and RESP

Behaviour:
- Reset values:
  - state=IDLE; last_grant=1, so req0 wins the first tie.
  - All operand registers, alu_* outputs, result registers, flags_q and respN_* are 0.
  - reqN_ready=0, busy=0.
- State machine: IDLE -> EXEC -> RESP -> IDLE. Each state lasts exactly one cycle except IDLE.
- IDLE:
  - If no reqN_valid is set, stay in IDLE.
  - If exactly one reqN_valid is set, grant that requester.
  - If both are set, grant the requester not equal to last_grant.
  - reqN_ready is combinational: (state==IDLE) & granted N.
  - On the handshake edge, latch the granted requester's fields into the operand registers, record grant id, update last_grant, and go to EXEC.
- EXEC:
  - alu_* outputs come from the operand registers only, so the ALU sees stable inputs for the whole cycle.
  - At the end of the cycle, capture alu_out and alu_flags into the result registers and go to RESP.
- RESP:
  - respN_valid=1 for the granted N only, with respN_out/respN_flags equal to the captured values.
  - The response has no backpressure; the requester must sink it.
  - If the latched s=1, flags_q takes the captured flags on the same edge that raises respN_valid, so the new value is visible in the RESP cycle. If s=0, flags_q is unchanged.
  - Go to IDLE.
- Timing:
  - Handshake at cycle T gives respN_valid in cycle T+2.
  - Maximum throughput is one operation per 3 cycles.
  - A request held valid but not granted stays pending; the requester must hold its fields stable until its ready is seen.
- Data:
  - resp outputs hold their last value between strobes; only respN_valid qualifies them.
  - The non-granted requester's respN_valid stays 0.
- Arithmetic is entirely in alu; the arbiter passes width-exact fields with no extension or truncation.
- Boundaries:
  - reqN_valid deasserted outside IDLE is ignored.
  - A requester that receives a response and raises valid in the following IDLE is arbitrated normally, so round-robin alternation holds under continuous contention.
  - rst in any state abandons the in-flight operation: no respN_valid, flags_q cleared, state returns to IDLE on the next edge.

Test Plan:
- Single op: req0 add (opcode 0000), in1=5, in2=3, s=1, handshake at T -> resp0_valid only in T+2, resp0_out=8, flags_q = alu_flags captured in EXEC, resp1_valid stays 0.
- Overflow: req1 add, in1=in2=32'h7FFFFFFF, s=1 -> resp1_out=32'hFFFFFFFE, resp1_flags and flags_q equal the alu's overflow flags, busy high for exactly 2 cycles.
- Tie after reset: req0 and req1 both valid and held -> grants in order 0,1,0,1; each respN_valid spaced 3 cycles apart.
- S=0: flags_q preloaded by an s=1 op, then req0 op with s=0 -> resp0_flags equals the new alu flags, flags_q unchanged.
- Reset mid-op: assert rst in EXEC -> no respN_valid, flags_q=0, state IDLE; a new req0 is accepted on the first cycle after rst deasserts.
- Late request: req1 raised during EXEC of a req0 op -> req1_ready first asserts in the IDLE cycle after RESP, never earlier.
